// File: rtl/fetch_unit.sv
// fetch_unit: PC/fetch sequencer with Start/Done handshake, branch-target LUT and run-cycle counter
//   Clk, Reset (sync, active-high), Start (level, ignored in RUN)
//   branch_en/branch_cond/FLAG_IN/target_idx/halt: decoded current-instruction controls
//   lut_wr_en/lut_wr_idx/lut_wr_data: LUT write port; PC, running, Done, cycle_count: registered outputs
module fetch_unit #(
  parameter int PC_W = 10,
  parameter int unsigned START_ADDR = 0,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             branch_en,
  input  logic             branch_cond,
  input  logic             FLAG_IN,
  input  logic [2:0]       target_idx,
  input  logic             halt,
  input  logic             lut_wr_en,
  input  logic [2:0]       lut_wr_idx,
  input  logic [PC_W-1:0]  lut_wr_data,
  output logic [PC_W-1:0]  PC,
  output logic             running,
  output logic             Done,
  output logic [CNT_W-1:0] cycle_count
);
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;
  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
  logic [1:0] state;
  logic [PC_W-1:0] lut [8];
  logic taken, accept;
  logic [PC_W-1:0] next_pc;
  // state bits double as the registered running/Done outputs
  assign running = state[0];
  assign Done = state[1];
  assign taken = branch_en && (FLAG_IN == branch_cond);
  assign accept = Start && (state != RUN);
  assign next_pc = halt ? PC : taken ? lut[target_idx] : PC + 1'b1;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      PC <= START_PC;
      cycle_count <= '0;
      for (int i = 0; i < 8; i++) lut[i] <= '0;
    end else begin
      // branch reads lut before this write lands, so a same-cycle collision sees the old entry
      if (lut_wr_en) lut[lut_wr_idx] <= lut_wr_data;
      if (accept) begin
        state <= RUN;
        PC <= START_PC;
        cycle_count <= '0;
      end else if (state == RUN) begin
        state <= halt ? DONE : RUN;
        PC <= next_pc;
        cycle_count <= &cycle_count ? cycle_count : cycle_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, counter saturation sequence and randomized model check
module tb_fetch_unit;
  localparam int PC_W = 10;
  localparam int CNT_W = 16;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
  logic Clk = 1'b0;
  logic Reset, Start, branch_en, branch_cond, FLAG_IN, halt, lut_wr_en;
  logic [2:0] target_idx, lut_wr_idx;
  logic [PC_W-1:0] lut_wr_data, PC;
  logic running, Done;
  logic [CNT_W-1:0] cycle_count;
  int n_chk = 0, n_fail = 0;
  int m_st, m_pc, m_cnt;
  int m_lut [8];
  typedef struct {
    string name;
    logic rst, start, ben, bcond, flag;
    logic [2:0] tidx;
    logic hlt, wen;
    logic [2:0] widx;
    logic [9:0] wdata, e_pc;
    logic e_run, e_done;
    logic [15:0] e_cnt;
  } vec_t;
  vec_t tbl[$];

  fetch_unit dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .branch_en(branch_en), .branch_cond(branch_cond),
    .FLAG_IN(FLAG_IN), .target_idx(target_idx), .halt(halt), .lut_wr_en(lut_wr_en),
    .lut_wr_idx(lut_wr_idx), .lut_wr_data(lut_wr_data), .PC(PC), .running(running),
    .Done(Done), .cycle_count(cycle_count)
  );

  always #5 Clk = ~Clk;

  function automatic vec_t mk(input string name, input logic rst, start, ben, bcond, flag,
                              input logic [2:0] tidx, input logic hlt, wen, input logic [2:0] widx,
                              input logic [9:0] wdata, e_pc, input logic e_run, e_done,
                              input logic [15:0] e_cnt);
    return '{name, rst, start, ben, bcond, flag, tidx, hlt, wen, widx, wdata, e_pc, e_run, e_done, e_cnt};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic rst, start, ben, bcond, flag, input logic [2:0] tidx,
                       input logic hlt, wen, input logic [2:0] widx, input logic [9:0] wdata);
    Reset = rst; Start = start; branch_en = ben; branch_cond = bcond; FLAG_IN = flag;
    target_idx = tidx; halt = hlt; lut_wr_en = wen; lut_wr_idx = widx; lut_wr_data = wdata;
  endtask

  // next-state of the fetch sequencer straight from the behavioural rules
  task automatic model_step();
    int tgt;
    if (Reset) begin
      m_st = M_IDLE; m_pc = 0; m_cnt = 0;
      foreach (m_lut[i]) m_lut[i] = 0;
      return;
    end
    tgt = m_lut[target_idx];
    if (lut_wr_en) m_lut[lut_wr_idx] = int'(lut_wr_data);
    if (Start && m_st != M_RUN) begin
      m_st = M_RUN; m_pc = 0; m_cnt = 0;
    end else if (m_st == M_RUN) begin
      m_cnt = (m_cnt < (1 << CNT_W) - 1) ? m_cnt + 1 : m_cnt;
      if (halt) m_st = M_DONE;
      else if (branch_en && FLAG_IN == branch_cond) m_pc = tgt;
      else m_pc = (m_pc + 1) % (1 << PC_W);
    end
  endtask

  initial begin
    tbl.push_back(mk("rst_a",     1,1,0,0,0,0,0,0,0,0,      0,0,0,0));
    tbl.push_back(mk("rst_b",     1,1,0,0,0,0,0,0,0,0,      0,0,0,0));
    tbl.push_back(mk("start",     0,1,0,0,0,0,0,0,0,0,      0,1,0,0));
    for (int k = 1; k <= 5; k++)
      tbl.push_back(mk($sformatf("seq%0d", k), 0,0,0,0,0,0,0,0,0,0, 10'(k),1,0,16'(k)));
    tbl.push_back(mk("halt5",     0,0,0,0,0,0,1,0,0,0,      5,0,1,6));
    tbl.push_back(mk("done_wr",   0,0,0,0,0,0,0,1,3,'h120,  5,0,1,6));
    tbl.push_back(mk("start2",    0,1,0,0,0,0,0,0,0,0,      0,1,0,0));
    tbl.push_back(mk("s2a",       0,0,0,0,0,0,0,0,0,0,      1,1,0,1));
    tbl.push_back(mk("s2b",       0,0,0,0,0,0,0,0,0,0,      2,1,0,2));
    tbl.push_back(mk("br_take",   0,0,1,1,1,3,0,0,0,0,      'h120,1,0,3));
    tbl.push_back(mk("halt_b",    0,0,0,0,0,0,1,0,0,0,      'h120,0,1,4));
    tbl.push_back(mk("start3",    0,1,0,0,0,0,0,0,0,0,      0,1,0,0));
    tbl.push_back(mk("s3a",       0,0,0,0,0,0,0,0,0,0,      1,1,0,1));
    tbl.push_back(mk("s3b",       0,0,0,0,0,0,0,0,0,0,      2,1,0,2));
    tbl.push_back(mk("br_not",    0,0,1,1,0,3,0,0,0,0,      3,1,0,3));
    tbl.push_back(mk("wr1",       0,0,0,0,0,0,0,1,1,'h050,  4,1,0,4));
    tbl.push_back(mk("collide",   0,0,1,0,0,1,0,1,1,'h060,  'h050,1,0,5));
    tbl.push_back(mk("br_new",    0,0,1,1,1,1,0,0,0,0,      'h060,1,0,6));
    tbl.push_back(mk("wr2",       0,0,0,0,0,0,0,1,2,'h3FF,  'h061,1,0,7));
    tbl.push_back(mk("br_top",    0,0,1,0,0,2,0,0,0,0,      'h3FF,1,0,8));
    tbl.push_back(mk("wrap",      0,0,0,0,0,0,0,0,0,0,      0,1,0,9));
    tbl.push_back(mk("halt_pri",  0,0,1,1,1,3,1,0,0,0,      0,0,1,10));
    tbl.push_back(mk("restart",   0,1,0,0,0,0,0,0,0,0,      0,1,0,0));
    for (int k = 1; k <= 7; k++)
      tbl.push_back(mk($sformatf("run%0d", k), 0,0,0,0,0,0,0,0,0,0, 10'(k),1,0,16'(k)));
    tbl.push_back(mk("rst_mid",   1,0,0,0,0,0,0,0,0,0,      0,0,0,0));
    tbl.push_back(mk("idle_a",    0,0,0,0,0,0,0,0,0,0,      0,0,0,0));
    tbl.push_back(mk("idle_b",    0,0,0,0,0,0,0,0,0,0,      0,0,0,0));
    tbl.push_back(mk("start4",    0,1,0,0,0,0,0,0,0,0,      0,1,0,0));
    tbl.push_back(mk("lut_clr",   0,0,1,1,1,3,0,0,0,0,      0,1,0,1));
    tbl.push_back(mk("after_clr", 0,0,0,0,0,0,0,0,0,0,      1,1,0,2));
    tbl.push_back(mk("start_ign", 0,1,0,0,0,0,0,0,0,0,      2,1,0,3));

    drive(1,0,0,0,0,0,0,0,0,0);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].start, tbl[i].ben, tbl[i].bcond, tbl[i].flag, tbl[i].tidx,
            tbl[i].hlt, tbl[i].wen, tbl[i].widx, tbl[i].wdata);
      @(posedge Clk); #1;
      check({tbl[i].name, ".pc"}, 32'(PC), 32'(tbl[i].e_pc));
      check({tbl[i].name, ".running"}, 32'(running), 32'(tbl[i].e_run));
      check({tbl[i].name, ".done"}, 32'(Done), 32'(tbl[i].e_done));
      check({tbl[i].name, ".cnt"}, 32'(cycle_count), 32'(tbl[i].e_cnt));
    end

    // long sequential run: counter saturates, PC wraps repeatedly
    drive(1,0,0,0,0,0,0,0,0,0); @(posedge Clk); #1;
    drive(0,1,0,0,0,0,0,0,0,0); @(posedge Clk); #1;
    drive(0,0,0,0,0,0,0,0,0,0);
    for (int k = 0; k < 65540; k++) @(posedge Clk);
    #1;
    check("sat.cnt", 32'(cycle_count), (1 << CNT_W) - 1);
    check("sat.pc", 32'(PC), 65540 % (1 << PC_W));
    check("sat.running", 32'(running), 1);

    drive(1,0,0,0,0,0,0,0,0,0);
    model_step();
    @(posedge Clk); #1;
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
            1'($urandom), 1'($urandom), 3'($urandom), $urandom_range(0, 24) == 0,
            $urandom_range(0, 3) == 0, 3'($urandom), 10'($urandom));
      model_step();
      @(posedge Clk); #1;
      check($sformatf("rnd%0d.pc", i), 32'(PC), m_pc);
      check($sformatf("rnd%0d.running", i), 32'(running), 32'(m_st == M_RUN));
      check($sformatf("rnd%0d.done", i), 32'(Done), 32'(m_st == M_DONE));
      check($sformatf("rnd%0d.cnt", i), 32'(cycle_count), m_cnt);
      check($sformatf("rnd%0d.excl", i), 32'(running & Done), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch sequencer for the 9-bit core. It takes the branch request produced by the control decoder together with the comparison flag, and chooses each cycle's next PC: sequential, branch target, or hold. It supplies the instruction ROM address and runs a Start/Done handshake with the test harness. It also contains an 8-entry branch-target lookup table, indexed by instruction bits [5:3], and a run-cycle counter.

## Interface
Parameters:
- PC_W, 10, PC and instruction-ROM address width
- START_ADDR, 0, PC value loaded on reset and on every accepted Start
- CNT_W, 16, cycle-counter width

Ports:
- Clk  input  1  clock; all state updates on its rising edge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  begin program execution; level, sampled every cycle
- branch_en  input  1  decoded branch instruction present (from the control decoder)
- branch_cond  input  1  flag value that causes the branch to be taken; 1 for fnB1, 0 for fnB0
- FLAG_IN  input  1  registered comparison flag
- target_idx  input  3  Instruction[5:3]; selects the LUT entry
- halt  input  1  decoded halt instruction present
- lut_wr_en  input  1  write enable for the LUT
- lut_wr_idx  input  3  LUT write index
- lut_wr_data  input  PC_W  LUT write data (absolute target address)
- PC  output  PC_W  current instruction address
- running  output  1  high in RUN
- Done  output  1  high in DONE
- cycle_count  output  CNT_W  number of cycles spent in RUN since the last accepted Start

## Operation
- States are IDLE, RUN and DONE.
- **IDLE:**
  - PC holds.
  - Start=1 loads PC=START_ADDR, clears cycle_count and moves to RUN.
- **RUN:** each cycle, with this priority:
  - halt=1: PC holds and the state moves to DONE. halt takes priority over branch_en.
  - Branch taken, i.e. branch_en=1 and FLAG_IN==branch_cond: PC = lut[target_idx].
  - Otherwise: PC = PC+1, modulo 2^PC_W. From 2^PC_W-1 the PC wraps to 0 with no error.
  - cycle_count increments on every RUN cycle, including the halt cycle. It saturates at all-ones.
  - Start is ignored in RUN.
- **DONE:**
  - PC and cycle_count hold; Done=1.
  - Start=1 restarts: PC=START_ADDR, cycle_count=0, next state RUN, Done drops the next cycle.
  - The harness must deassert Start before the halt is reached. A Start held high through DONE restarts immediately.
- **LUT:**
  - 8 x PC_W registers, written when lut_wr_en=1. Writes are legal in any state.
  - Read is combinational.
  - A write and a taken branch to the same index in the same cycle: the branch uses the old entry. The new value is visible from the next cycle.
- Invariant: running and Done are never both high.
- **Reset:** valid in any state, including mid-RUN. It aborts execution and sets:
  - state=IDLE, PC=START_ADDR
  - running=0, Done=0, cycle_count=0
  - all LUT entries=0
  - Reset has priority over Start and over LUT writes.

## Timing
- PC, running, Done and cycle_count are registered, with no combinational path from inputs to outputs.
- The instruction ROM is combinational: the instruction for PC is valid in the same cycle. The decoded branch_en, branch_cond, target_idx and halt are evaluated in that cycle, and the chosen next PC appears after the following rising edge.
- Start to first fetch:
  - Start is sampled high at edge N.
  - PC=START_ADDR and running=1 after edge N.
  - The first instruction executes in cycle N+1.
- Halt: halt is seen in cycle K. After edge K: running=0, Done=1, and PC is still the address of the halt instruction.
- Branch latency is zero bubbles: the target instruction executes in the cycle immediately after the branch.
- Reset asserted at edge R: all outputs take their reset values after edge R.

## Test plan
1. **Reset.** Assert Reset for 2 cycles with Start=1.
   - Required: PC=0, running=0, Done=0, cycle_count=0; LUT reads 0.
2. **Sequential run and halt.** Pulse Start, then feed no branches and assert halt when PC=5.
   - Required: PC sequence 0,1,2,3,4,5; Done=1 from the next cycle; PC stays 5; cycle_count=6.
3. **Branch taken and not taken.** Write lut[3]=0x120. At PC=2 set branch_en=1, branch_cond=1, target_idx=3.
   - With FLAG_IN=1: next PC=0x120.
   - Repeat with FLAG_IN=0: next PC=3.
4. **Write/branch collision and wrap.**
   - lut[1]=0x050. In the same cycle write lut[1]=0x060 and take a branch to index 1: PC becomes 0x050. A later branch to index 1 gives 0x060.
   - Branch to 0x3FF, then advance sequentially: PC goes to 0x000.
5. **Halt priority and restart.**
   - halt=1 and a taken branch in the same cycle: PC holds and the state moves to DONE.
   - Then pulse Start: PC=0, running=1, Done=0, cycle_count restarts at 0.
6. **Reset mid-run.** Assert Reset at PC=7 in RUN.
   - Required: after that edge PC=0 and the state is IDLE. With Start low, the PC holds at 0 indefinitely.
